dm_banked_mem: RTL and testbench
================================

Name: dm_banked_mem

Overview:
- Parametrised, byte-addressable data memory for the MIPS datapath; next-generation load/store memory.
- Adds sub-word accesses (byte/half/word) with optional sign extension, configurable depth and wait states, a req/ready/rvalid handshake, and range/size error reporting.
- Sits between the ALU address output and the register-file write-back mux.
- Byte order is big-endian: the lowest address holds the MSB.

Parameters:
- DEPTH_BYTES, 1024, memory size in bytes; power of two, at least 4.
- ADDR_W, 32, address port width.
- WAIT_STATES, 0, extra cycles between acceptance and response; range 0..15.
- INIT_FILE, "DM.list", binary image loaded at time 0; empty string means no preload.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  access request.
- we  in  1  1 = store, 0 = load; sampled on acceptance.
- size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, right-justified.
- ready  out  1  block can accept a request this cycle.
- rvalid  out  1  one-cycle response pulse; returned for loads and stores.
- rdata  out  32  load result; valid while rvalid is high.
- err  out  1  error flag; qualified by rvalid.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, ready=0 during reset then 1, rvalid=0, rdata=0, err=0. Memory array is not cleared.
- Acceptance: posedge where req && ready. we, size, sign_ext, addr and wdata are latched at this edge; input changes afterwards are ignored.
- FSM states:
  - IDLE: ready=1. On acceptance: go to WAIT if WAIT_STATES>0, else RESP.
  - WAIT: ready=0. A counter loads WAIT_STATES-1 and decrements; go to RESP at 0.
  - RESP: rvalid=1, ready=1. Acceptance in this cycle allowed (back-to-back) and follows the IDLE rules; otherwise go to IDLE.
- Latency: rvalid is high exactly WAIT_STATES+1 cycles after the accept edge. Throughput is one access per WAIT_STATES+1 cycles.
- Commit point: store write and load read both occur at the edge entering RESP. A load accepted in the RESP cycle of a store sees the new data.
- Load formatting:
  - byte: rdata[7:0] = mem[a].
  - half: rdata[15:0] = {mem[a], mem[a+1]}.
  - word: rdata = {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
  - Upper bits are the sign bit when sign_ext=1, else 0. sign_ext is ignored for word loads.
- Stores: byte writes wdata[7:0] to mem[a]. Half writes wdata[15:8] to mem[a] and wdata[7:0] to mem[a+1]. Word writes all four bytes. Unaddressed bytes are untouched.
- Errors, reported in the RESP cycle with err=1, rdata=0 and no memory write:
  - size==3.
  - a + nbytes > DEPTH_BYTES (no wrap-around).
- rdata holds its last value outside rvalid; err is 0 whenever rvalid=0.
- Reset asserted mid-WAIT: pending access is dropped, no write, no rvalid.

Optional Feature:
- Macro DM_ALIGN_CHECK_EN.
- Defined: a half access with a[0]!=0, or a word access with a[1:0]!=0, gives err=1 with no write and rdata=0.
- Undefined: low address bits are forced to 0 for half/word (a&~1, a&~3) and the access completes normally with err=0.

Decomposition:
- Package dm_pkg:
  - size encodings SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2.
  - FSM state enum IDLE/WAIT/RESP.
  - function nbytes(size).
- Sub-module dm_lane_fmt (combinational): takes 4 raw bytes, size and sign_ext; produces the formatted rdata. It is the single place for extension rules and is unit-testable.

Test Plan:
- WAIT_STATES=0: sw 0xDEADBEEF @0x10, then lw @0x10. rvalid 1 cycle after each accept; rdata=0xDEADBEEF; mem[0x10]=0xDE.
- lb @0x10 with sign_ext=1 gives 0xFFFFFFDE; sign_ext=0 gives 0x000000DE. lh @0x12 with sign_ext=1 gives 0xFFFFBEEF.
- sb 0x55 @0x11, then lw @0x10: 0xDE55BEEF. sh 0x1234 @0x12, then lw: 0xDE551234.
- WAIT_STATES=3: req held high continuously. ready low 3 cycles; rvalid exactly 4 cycles after accept; next accept in the rvalid cycle.
- Errors: lw @DEPTH_BYTES-2 gives err=1, rdata=0. size=3 gives err=1. sw @0x3FD gives err=1 with memory unchanged. Misaligned lw @0x11 gives err=1 with DM_ALIGN_CHECK_EN, or returns the word @0x10 with err=0 without it.
- Store accepted with WAIT_STATES=3, rst_n pulsed low in the 2nd wait cycle: no rvalid, target bytes unchanged, ready=1 after release.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared encodings and helpers for the banked data memory.
// Pure definitions: no latency, no flow control.
// No backpressure; imported by the memory top and its lane formatter.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Request fields captured at the accept edge and replayed at commit.
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] wdata;
  } acc_t;

  function automatic logic [2:0] nbytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: nbytes = 3'd1;
      SZ_HALF: nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_fmt.sv
// Formats four big-endian raw bytes into a right-justified load result.
// Latency: combinational.
// Backpressure: none.
module dm_lane_fmt
  import dm_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] rdata
);

  // raw[31:24] is the byte at the lowest address, so sub-word loads take the top lanes.
  always_comb begin
    rdata = '0;
    case (size)
      SZ_BYTE: rdata = {{24{sign_ext & raw[31]}}, raw[31:24]};
      SZ_HALF: rdata = {{16{sign_ext & raw[31]}}, raw[31:16]};
      SZ_WORD: rdata = raw;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/dm_banked_mem.sv
// Byte-addressable big-endian data memory, req/ready/rvalid; DM_ALIGN_CHECK_EN adds misalignment errors.
// Latency: rvalid exactly WAIT_STATES+1 cycles after the accept edge.
// Backpressure: ready drops during wait states; back-to-back accept allowed in the response cycle.
module dm_banked_mem
  import dm_pkg::*;
#(
  parameter int    DEPTH_BYTES = 1024,
  parameter int    ADDR_W      = 32,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = "DM.list"
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              rvalid,
  output logic [31:0]       rdata,
  output logic              err
);

  localparam int         IDX_W    = $clog2(DEPTH_BYTES);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  acc_t              lat_q, lat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [7:0]        mem [DEPTH_BYTES];

  logic              accept, commit;
  acc_t              live_acc, cur_acc;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W:0]   end_addr;
  logic              size_err, range_err, align_err, acc_err;
  logic [IDX_W-1:0]  base;
  logic [IDX_W-1:0]  idx [4];
  logic [3:0]        be;
  logic [31:0]       wbytes, raw, fmt_rdata;

  assign ready    = rst_n && (state_q != ST_WAIT);
  assign rvalid   = (state_q == ST_RESP);
  assign rdata    = rdata_q;
  assign err      = err_q;
  assign accept   = req && ready;
  assign live_acc = '{we: we, size: size, sign_ext: sign_ext, wdata: wdata};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    addr_d  = addr_q;
    if (accept) begin
      lat_d  = live_acc;
      addr_d = addr;
    end
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Every entry into RESP is a commit; with no wait states the live inputs are the access.
  assign commit = (state_d == ST_RESP);

  always_comb begin
    cur_acc   = (state_q == ST_WAIT) ? lat_q : live_acc;
    cur_addr  = (state_q == ST_WAIT) ? addr_q : addr;
    end_addr  = {1'b0, cur_addr} + (ADDR_W+1)'(nbytes(cur_acc.size));
    size_err  = (cur_acc.size == SZ_RSVD);
    range_err = (end_addr > (ADDR_W+1)'(DEPTH_BYTES));
`ifdef DM_ALIGN_CHECK_EN
    align_err = ((cur_acc.size == SZ_HALF) && cur_addr[0]) ||
                ((cur_acc.size == SZ_WORD) && (cur_addr[1:0] != 2'b00));
    base      = cur_addr[IDX_W-1:0];
`else
    align_err = 1'b0;
    case (cur_acc.size)
      SZ_HALF: base = {cur_addr[IDX_W-1:1], 1'b0};
      SZ_WORD: base = {cur_addr[IDX_W-1:2], 2'b00};
      default: base = cur_addr[IDX_W-1:0];
    endcase
`endif
    acc_err = size_err || range_err || align_err;
    for (int i = 0; i < 4; i++) idx[i] = base + IDX_W'(i);
    case (cur_acc.size)
      SZ_BYTE: begin be = 4'b0001; wbytes = {cur_acc.wdata[7:0], 24'd0};  end
      SZ_HALF: begin be = 4'b0011; wbytes = {cur_acc.wdata[15:0], 16'd0}; end
      SZ_WORD: begin be = 4'b1111; wbytes = cur_acc.wdata;                end
      default: begin be = 4'b0000; wbytes = '0;                           end
    endcase
  end

  assign raw = {mem[idx[0]], mem[idx[1]], mem[idx[2]], mem[idx[3]]};

  dm_lane_fmt u_fmt (
    .raw      (raw),
    .size     (cur_acc.size),
    .sign_ext (cur_acc.sign_ext),
    .rdata    (fmt_rdata)
  );

  always_comb begin
    rdata_d = rdata_q;
    err_d   = 1'b0;
    if (commit) begin
      err_d   = acc_err;
      rdata_d = (acc_err || cur_acc.we) ? 32'd0 : fmt_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && !acc_err && cur_acc.we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx[i]] <= wbytes[8*(3-i) +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dm_banked_mem.sv
// Scoreboard bench: two instances (0 and 3 wait states) driven with directed and random accesses.
module tb_dm_banked_mem;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        s_rst_n [2];
  logic        s_req   [2];
  logic        s_we    [2];
  logic [1:0]  s_size  [2];
  logic        s_sx    [2];
  logic [31:0] s_addr  [2];
  logic [31:0] s_wdata [2];
  logic        s_ready [2];
  logic        s_rvalid[2];
  logic [31:0] s_rdata [2];
  logic        s_err   [2];

  typedef struct {
    bit          we;
    logic [31:0] rd;
    bit          er;
    int          acc;
  } exp_t;

  exp_t        q0[$], q1[$];
  logic [7:0]  mm [2][DEPTH];
  logic [31:0] last_rd [2];
  bit          known   [2];
  int          last_acc[2];
  int          cyc   = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_banked_mem #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .WAIT_STATES(0), .INIT_FILE("")) u_dut0 (
    .clk(clk), .rst_n(s_rst_n[0]), .req(s_req[0]), .we(s_we[0]), .size(s_size[0]),
    .sign_ext(s_sx[0]), .addr(s_addr[0]), .wdata(s_wdata[0]), .ready(s_ready[0]),
    .rvalid(s_rvalid[0]), .rdata(s_rdata[0]), .err(s_err[0])
  );

  dm_banked_mem #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .WAIT_STATES(3), .INIT_FILE("")) u_dut3 (
    .clk(clk), .rst_n(s_rst_n[1]), .req(s_req[1]), .we(s_we[1]), .size(s_size[1]),
    .sign_ext(s_sx[1]), .addr(s_addr[1]), .wdata(s_wdata[1]), .ready(s_ready[1]),
    .rvalid(s_rvalid[1]), .rdata(s_rdata[1]), .err(s_err[1])
  );

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic flag(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  // Reference: big-endian byte array, range checked before any alignment handling.
  task automatic model(input int k, input bit w, input logic [1:0] sz, input bit sx,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output bit er);
    int     n;
    int     base;
    longint v;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    er = 0;
    rd = 32'd0;
    if (n == 0 || longint'(a) + n > DEPTH) er = 1;
`ifdef DM_ALIGN_CHECK_EN
    if (!er && (a % n) != 0) er = 1;
`endif
    if (!er) begin
      base = int'(a) - int'(a % n);
      if (w) begin
        for (int i = 0; i < n; i++) mm[k][base + i] = 8'(wd >> (8 * (n - 1 - i)));
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v = (v << 8) | longint'(mm[k][base + i]);
        if (sx && n < 4 && ((v >> (8 * n - 1)) & 1) == 1) v = v - (longint'(1) << (8 * n));
        rd = v[31:0];
      end
    end
  endtask

  task automatic issue(input int k, input bit w, input logic [1:0] sz, input bit sx,
                       input logic [31:0] a, input logic [31:0] wd,
                       input bit exp_resp, input int exp_gap);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (!s_ready[k] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!s_ready[k]) begin
      flag($sformatf("ready_timeout dut%0d: ready stayed 0 for 50 cycles, required 1", k));
      return;
    end
    s_req[k] = 1'b1; s_we[k] = w; s_size[k] = sz; s_sx[k] = sx; s_addr[k] = a; s_wdata[k] = wd;
    if (exp_gap > 0) chk($sformatf("accept_gap dut%0d", k), 32'(cyc - last_acc[k]), 32'(exp_gap));
    last_acc[k] = cyc;
    if (exp_resp) begin
      e.we  = w;
      e.acc = cyc;
      model(k, w, sz, sx, a, wd, e.rd, e.er);
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic drain(input int k);
    int t;
    t = 0;
    @(negedge clk);
    s_req[k] = 1'b0;
    while (qsize(k) != 0 && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (qsize(k) != 0) flag($sformatf("drain_timeout dut%0d: %0d responses missing, required 0", k, qsize(k)));
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (s_rvalid[k]) begin
        if (qsize(k) == 0) begin
          flag($sformatf("unexpected_rvalid dut%0d: got rvalid=1, required no response", k));
        end else begin
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("err dut%0d", k), {31'd0, s_err[k]}, {31'd0, e.er});
          chk($sformatf("latency dut%0d", k), 32'(cyc - e.acc), 32'(ws_of(k) + 1));
          if (!e.we || e.er) begin
            chk($sformatf("rdata dut%0d", k), s_rdata[k], e.rd);
            last_rd[k] = e.rd;
            known[k]   = 1;
          end else begin
            known[k] = 0;
          end
        end
      end else begin
        chk($sformatf("err_idle dut%0d", k), {31'd0, s_err[k]}, 32'd0);
        if (known[k]) chk($sformatf("rdata_hold dut%0d", k), s_rdata[k], last_rd[k]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          r;
    for (int k = 0; k < 2; k++) begin
      s_rst_n[k] = 1'b0; s_req[k] = 1'b0; s_we[k] = 1'b0; s_size[k] = 2'd0;
      s_sx[k] = 1'b0; s_addr[k] = '0; s_wdata[k] = '0;
      last_rd[k] = 32'd0; known[k] = 1; last_acc[k] = 0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_ready dut%0d", k), {31'd0, s_ready[k]}, 32'd0);
      chk($sformatf("reset_rvalid dut%0d", k), {31'd0, s_rvalid[k]}, 32'd0);
      chk($sformatf("reset_rdata dut%0d", k), s_rdata[k], 32'd0);
      chk($sformatf("reset_err dut%0d", k), {31'd0, s_err[k]}, 32'd0);
      s_rst_n[k] = 1'b1;
    end
    #1;
    for (int k = 0; k < 2; k++) chk($sformatf("ready_after_reset dut%0d", k), {31'd0, s_ready[k]}, 32'd1);

    // Fill both memories so every later read has a known reference.
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < DEPTH / 4; w++) issue(k, 1, 2'd2, 0, 32'(4 * w), $urandom, 1, 0);
      drain(k);
    end

    // Sub-word accesses, req held high, one access per cycle.
    issue(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 1, 0);
    issue(0, 0, 2'd2, 0, 32'h10, 32'h0, 1, 1);
    issue(0, 0, 2'd0, 1, 32'h10, 32'h0, 1, 1);
    issue(0, 0, 2'd0, 0, 32'h10, 32'h0, 1, 1);
    issue(0, 0, 2'd1, 1, 32'h12, 32'h0, 1, 1);
    issue(0, 1, 2'd0, 0, 32'h11, 32'h55, 1, 1);
    issue(0, 0, 2'd2, 0, 32'h10, 32'h0, 1, 1);
    issue(0, 1, 2'd1, 0, 32'h12, 32'h1234, 1, 1);
    issue(0, 0, 2'd2, 0, 32'h10, 32'h0, 1, 1);
    drain(0);

    // Range, size and alignment boundaries.
    issue(0, 0, 2'd2, 0, 32'(DEPTH - 2), 32'h0, 1, 0);
    issue(0, 0, 2'd3, 0, 32'h20, 32'h0, 1, 0);
    issue(0, 1, 2'd2, 0, 32'h3FD, 32'hCAFEF00D, 1, 0);
    issue(0, 0, 2'd2, 0, 32'h3FC, 32'h0, 1, 0);
    issue(0, 0, 2'd2, 0, 32'h11, 32'h0, 1, 0);
    issue(0, 0, 2'd0, 1, 32'(DEPTH - 1), 32'h0, 1, 0);
    issue(0, 0, 2'd1, 0, 32'(DEPTH - 1), 32'h0, 1, 0);
    issue(0, 0, 2'd1, 1, 32'h13, 32'h0, 1, 0);
    issue(0, 0, 2'd2, 0, 32'h8000_0010, 32'h0, 1, 0);
    drain(0);

    // Three wait states with req held high: accepts four cycles apart.
    issue(1, 1, 2'd2, 0, 32'h10, 32'h89ABCDEF, 1, 0);
    issue(1, 0, 2'd2, 0, 32'h10, 32'h0, 1, 4);
    issue(1, 0, 2'd1, 1, 32'h10, 32'h0, 1, 4);
    issue(1, 0, 2'd0, 0, 32'h13, 32'h0, 1, 4);
    drain(1);

    // Reset in the second wait cycle drops a pending store.
    issue(1, 1, 2'd2, 0, 32'h40, 32'hA5A5A5A5, 0, 0);
    @(negedge clk);
    s_req[1] = 1'b0;
    @(negedge clk);
    known[1]   = 0;
    s_rst_n[1] = 1'b0;
    #1;
    chk("ready_in_reset dut1", {31'd0, s_ready[1]}, 32'd0);
    repeat (2) @(negedge clk);
    s_rst_n[1] = 1'b1;
    last_rd[1] = 32'd0;
    known[1]   = 1;
    #1;
    chk("ready_after_midreset dut1", {31'd0, s_ready[1]}, 32'd1);
    issue(1, 0, 2'd2, 0, 32'h40, 32'h0, 1, 0);
    drain(1);

    for (int k = 0; k < 2; k++) begin
      for (int it = 0; it < 250; it++) begin
        r  = $urandom_range(0, 9);
        a  = (r < 7) ? 32'($urandom_range(0, DEPTH - 1)) :
             (r < 9) ? 32'(DEPTH - 4 + $urandom_range(0, 3)) : $urandom;
        sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        issue(k, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1, 0);
        if ($urandom_range(0, 3) == 0) drain(k);
      end
      drain(k);
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
